// File: rtl/ext_mem_pkg.sv
// Shared types and limits for the latency-programmable external memory model.
package ext_mem_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {OKAY, ERR} resp_e;
  localparam int MAX_LAT = 15;
  localparam int CNT_W   = 4;
endpackage

// File: rtl/ext_mem_if.sv
// Request/response bus between a memory master and ext_mem_lat.
interface ext_mem_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [STRB_WIDTH-1:0] mem_strb;
  logic                  mem_ready;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_err;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wr_data, mem_strb,
    input  mem_ready, mem_resp_valid,
    input  mem_rd_data, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wr_data, mem_strb,
    output mem_ready, mem_resp_valid,
    output mem_rd_data, mem_err
  );
endinterface

// File: rtl/ext_mem_array.sv
// DEPTH x DATA_WIDTH storage, strobe-masked write, registered read.
module ext_mem_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] strb,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (strb[i]) mem[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (rd_en) rd_data <= mem[addr];
  end
endmodule

// File: rtl/ext_mem_lat.sv
// External memory model with programmable read/write latency and
// out-of-range error responses; one transaction in flight.
module ext_mem_lat
  import ext_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic     mem_clk,
  input  logic     mem_rst_n,
  ext_mem_if.slave bus
);
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH) ||
      RD_LATENCY < 1 || RD_LATENCY > MAX_LAT ||
      WR_LATENCY < 1 || WR_LATENCY > MAX_LAT ||
      DATA_WIDTH % 8 != 0) begin : g_bad_param
    $error("ext_mem_lat: illegal parameter value");
  end

  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  accept, done;
  logic                  we_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  resp_valid_q;
  resp_e                 resp_q;
  logic                  rd_ok_q;
  logic [DATA_WIDTH-1:0] arr_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = bus.mem_we ? WR_CNT : RD_CNT;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= OKAY;
      rd_ok_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= done;
      if (accept) begin
        we_q    <= bus.mem_we;
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wr_data;
        strb_q  <= bus.mem_strb;
        err_q   <= {1'b0, bus.mem_addr} >= DEPTH_W;
      end
      if (done) begin
        resp_q <= err_q ? ERR : OKAY;
        // rd_ok_q masks the unreset array output to zero after reset or an error read
        if (!we_q) rd_ok_q <= !err_q;
      end
    end
  end

  ext_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk    (mem_clk),
    .wr_en  (done && we_q && !err_q),
    .rd_en  (done && !we_q && !err_q),
    .addr   (addr_q),
    .wr_data(wdata_q),
    .strb   (strb_q),
    .rd_data(arr_rdata)
  );

  assign bus.mem_ready      = (state_q == IDLE);
  assign bus.mem_resp_valid = resp_valid_q;
  assign bus.mem_err        = (resp_q == ERR);
  assign bus.mem_rd_data    = rd_ok_q ? arr_rdata : '0;
endmodule

// File: doc/ext_mem_lat.md
Name: ext_mem_lat

Overview:
- Parametrised successor to the team's simple external memory model: a single-port, byte-strobed RAM with a request/ready handshake.
- Read and write latencies are programmable, and out-of-range accesses return an error response.
- Sits behind the APB slave's memory-side interface and models realistic external memory timing, with one transaction outstanding at a time.
- Array contents are not cleared by reset; only control state is.

Parameters:
ADDR_WIDTH  10  word-address width
DATA_WIDTH  32  data width, multiple of 8
STRB_WIDTH  DATA_WIDTH/8  byte-strobe width
DEPTH  1024  implemented words; legal range 1..2**ADDR_WIDTH
RD_LATENCY  2  accept-to-read-response cycles; legal range 1..15
WR_LATENCY  1  accept-to-write-response cycles; legal range 1..15

Ports:
mem_clk  in  1  clock
mem_rst_n  in  1  asynchronous active-low reset
mem_req  in  1  request valid
mem_we  in  1  1 = write, 0 = read
mem_addr  in  ADDR_WIDTH  word address
mem_wr_data  in  DATA_WIDTH  write data
mem_strb  in  STRB_WIDTH  byte enables, writes only
mem_ready  out  1  request accepted when mem_req && mem_ready
mem_resp_valid  out  1  one-cycle response pulse
mem_rd_data  out  DATA_WIDTH  read data, valid with a read response
mem_err  out  1  address error, valid with mem_resp_valid

Behaviour:
- Interface: reset mem_rst_n, asynchronous, active-low; clock mem_clk.
- Reset values: state IDLE, mem_resp_valid=0, mem_err=0, mem_rd_data=0, counter=0.
  - Reset mid-transaction aborts it; a pending write is discarded and no response is produced.
  - Array contents are retained through reset.
- FSM states: IDLE, BUSY.
  - mem_ready = (state==IDLE), decoded combinationally from state.
- Accept at edge T, when mem_req && mem_ready:
  - register we, addr, wr_data, strb;
  - set err_q = (addr >= DEPTH);
  - load counter with L-1, where L = RD_LATENCY for reads and WR_LATENCY for writes;
  - move to BUSY.
- BUSY, counter != 0: decrement the counter. mem_req is ignored; the master holds the request until ready.
- BUSY, counter == 0 (edge T+L): complete the transaction and return to IDLE.
  - mem_resp_valid <= 1 and mem_err <= err_q.
  - Write with err_q=0: for each i with strb[i]=1, array[addr] byte i <= wr_data byte i. Strb all-zero is a legal no-op and still responds.
  - Read with err_q=0: mem_rd_data <= array[addr].
  - Read with err_q=1: mem_rd_data <= 0.
  - Any write with err_q=1: array is untouched.
- Timing: the response is high during the cycle after edge T+L, so L=1 responds on the next cycle.
  - mem_ready is high in that same cycle, so a back-to-back accept is allowed.
  - Peak throughput is one transaction per L+1 cycles.
- mem_resp_valid is cleared on every edge that does not complete a transaction.
- mem_rd_data holds its value until the next read completion; writes do not change it.
- mem_err is meaningful only while mem_resp_valid=1; it is held otherwise.
- Read-after-write: the array is updated and read at completion, so a read accepted in the write-response cycle returns the new data.
- Address arithmetic:
  - the DEPTH compare is unsigned, full ADDR_WIDTH;
  - there is no wrap-around; the array is indexed only when addr < DEPTH.
- Parameter checks: elaboration-time assertion on the DEPTH and latency ranges.
  - The counter is 4 bits, sized for a maximum latency of 15.

Decomposition:
- Package ext_mem_pkg:
  - state enum {IDLE, BUSY};
  - MAX_LAT=15 and CNT_W=4;
  - resp type {OKAY, ERR}.
- Sub-module ext_mem_array: DEPTH x DATA_WIDTH storage.
  - One strobe-masked write port and one synchronous read port.
  - No reset.
  - Enables are driven by the FSM at completion only.
- Top-level: FSM, counter, request capture registers, address check.

Test Plan:
1. Reset, write 0xDEADBEEF to addr 5 (strb 4'hF), then read addr 5 -> resp_valid one cycle after edge T+1 (write) and after edge T+2 (read), rd_data=0xDEADBEEF, err=0.
2. Write 0x11223344 with strb 4'b0101 over 0xDEADBEEF at addr 5, then read -> 0xDE22BE44.
3. RD_LATENCY=4: hold mem_req high across the read -> ready low for 4 cycles, exactly one resp_valid pulse, and the next accept occurs in the response cycle.
4. DEPTH=1000: write addr 1000, then read addr 1000 -> err=1 on both and rd_data=0. A read of addr 999 afterwards returns its prior contents unchanged.
5. Assert reset while BUSY with a write to addr 7 pending -> resp_valid never asserts, ready=1 after reset, and a read of addr 7 returns its pre-write value.
6. Write to addr 3, then a read of addr 3 accepted in the write-response cycle -> the read returns the new data, with rd_data stable until the read response.
